// File: rtl/jam_pkg.sv
// Shared definitions for the job-assignment cost host.
// Contents:
//   N, COST_W    matrix geometry (N x N entries of COST_W bits)
//   MIN_W/CNT_W  widths of the solver's MinCost / MatchCount results
//   state_t      host FSM encoding
//   idx(W,J)     flat matrix index, worker-major: W*N+J
package jam_pkg;
    localparam int N      = 8;
    localparam int COST_W = 7;
    localparam int MIN_W  = 10;
    localparam int CNT_W  = 4;
    localparam int WJ_W   = $clog2(N);
    localparam int IDX_W  = $clog2(N * N);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    function automatic logic [IDX_W-1:0] idx(input logic [WJ_W-1:0] w,
                                             input logic [WJ_W-1:0] j);
        return IDX_W'(int'(w) * N + int'(j));
    endfunction
endpackage

// File: rtl/jam_cost_host_if.sv
// Bus between the testbench/solver side and the cost host.
// Signals:
//   ld_valid/ld_ready/ld_data   cost matrix load port (valid/ready)
//   W/J -> Cost                 combinational cost lookup used by the solver
//   Valid/MinCost/MatchCount    solver result
// Modports: master drives loads, lookups and results; slave is the host.
interface jam_cost_host_if;
    import jam_pkg::*;

    logic              ld_valid;
    logic              ld_ready;
    logic [COST_W-1:0] ld_data;
    logic [WJ_W-1:0]   W;
    logic [WJ_W-1:0]   J;
    logic [COST_W-1:0] Cost;
    logic              Valid;
    logic [MIN_W-1:0]  MinCost;
    logic [CNT_W-1:0]  MatchCount;

    modport master (
        output ld_valid, ld_data, W, J, Valid, MinCost, MatchCount,
        input  ld_ready, Cost
    );

    modport slave (
        input  ld_valid, ld_data, W, J, Valid, MinCost, MatchCount,
        output ld_ready, Cost
    );
endinterface

// File: rtl/jam_cost_mem.sv
// Cost matrix register file: one synchronous write port, one combinational
// read port. Contents are not reset.
// Ports:
//   CLK          clock
//   we/waddr/wdata  write port
//   raddr/rdata     asynchronous read port
module jam_cost_mem #(
    parameter int DEPTH = 64,
    parameter int DW    = 7,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/jam_cost_host.sv
// Host side of the job-assignment cost interface. Loads an N x N cost matrix,
// holds the solver in reset until matrix and expected results are present,
// serves Cost for the solver's (W,J), then checks the solver's result.
// Ports:
//   CLK, RST                clock, asynchronous active-high reset
//   bus (slave)             load port, cost lookup, solver result
//   exp_valid/exp_min/exp_count  expected-result strobe (IDLE/LOAD only)
//   start                   in DONE: clear results, back to IDLE
//   jam_rst                 reset to the solver, low only in RUN
//   done/pass/fail_min/fail_count/timeout  result flags, held in DONE
//   cycles                  RUN cycles until capture/timeout (saturating)
module jam_cost_host
    import jam_pkg::*;
#(
    parameter int TIMEOUT = 4096,
    parameter int CYC_W   = 16
) (
    input  logic               CLK,
    input  logic               RST,
    jam_cost_host_if.slave     bus,
    input  logic               exp_valid,
    input  logic [MIN_W-1:0]   exp_min,
    input  logic [CNT_W-1:0]   exp_count,
    input  logic               start,
    output logic               jam_rst,
    output logic               done,
    output logic               pass,
    output logic               fail_min,
    output logic               fail_count,
    output logic               timeout,
    output logic [CYC_W-1:0]   cycles
);
    localparam int DEPTH = N * N;
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT - 1);
    localparam logic [CYC_W-1:0] CYC_MAX  = '1;

    state_t            state, state_nxt;
    logic [PTR_W-1:0]  wr_ptr;
    logic              exp_loaded;
    logic [MIN_W-1:0]  exp_min_q;
    logic [CNT_W-1:0]  exp_count_q;
    logic              full, loading, accept, capture, expire;
    logic [COST_W-1:0] rd_data;

    assign full         = (wr_ptr == PTR_W'(DEPTH));
    assign loading      = (state == IDLE) || (state == LOAD);
    assign bus.ld_ready = loading && !full;
    assign accept       = bus.ld_valid && bus.ld_ready;
    assign capture      = (state == RUN) && bus.Valid;
    // A result in the last allowed cycle still counts as a capture.
    assign expire       = (state == RUN) && !bus.Valid && (cycles == CYC_LAST);
    // The solver samples Cost in the same cycle it presents W/J.
    assign bus.Cost     = (state == RUN) ? rd_data : '0;

    jam_cost_mem #(.DEPTH(DEPTH), .DW(COST_W), .AW(IDX_W)) u_mem (
        .CLK   (CLK),
        .we    (accept),
        .waddr (wr_ptr[IDX_W-1:0]),
        .wdata (bus.ld_data),
        .raddr (idx(bus.W, bus.J)),
        .rdata (rd_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)                 state_nxt = LOAD;
            // Matrix full but no expected values yet: wait here, ld_ready low.
            LOAD:    if (full && exp_loaded)     state_nxt = RUN;
            RUN:     if (capture || expire)      state_nxt = DONE;
            DONE:    if (start)                  state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            jam_rst     <= 1'b1;
            wr_ptr      <= '0;
            exp_loaded  <= 1'b0;
            exp_min_q   <= '0;
            exp_count_q <= '0;
            cycles      <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_min    <= 1'b0;
            fail_count  <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            // Registered from next state so the solver leaves reset on the first RUN cycle.
            jam_rst <= (state_nxt != RUN);
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (loading && exp_valid) begin
                exp_min_q   <= exp_min;
                exp_count_q <= exp_count;
                exp_loaded  <= 1'b1;
            end
            case (state)
                LOAD: begin
                    if (state_nxt == RUN) begin
                        cycles <= '0;
                    end
                end
                RUN: begin
                    if (capture) begin
                        done       <= 1'b1;
                        fail_min   <= (bus.MinCost != exp_min_q);
                        fail_count <= (bus.MatchCount != exp_count_q);
                        pass       <= (bus.MinCost == exp_min_q) &&
                                      (bus.MatchCount == exp_count_q);
                    end else if (expire) begin
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else if (cycles != CYC_MAX) begin
                        cycles <= cycles + 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        wr_ptr     <= '0;
                        exp_loaded <= 1'b0;
                        cycles     <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail_min   <= 1'b0;
                        fail_count <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_jam_cost_host.sv
// Bench for jam_cost_host. Two hosts share one stimulus stream: d0 with the
// default TIMEOUT, d1 with TIMEOUT=64. A per-cycle model predicts every output.
module tb_jam_cost_host;
    import jam_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic       exp_valid = 1'b0;
    logic [9:0] exp_min   = '0;
    logic [3:0] exp_count = '0;
    logic       start     = 1'b0;

    jam_cost_host_if bus0 ();
    jam_cost_host_if bus1 ();

    assign bus1.ld_valid   = bus0.ld_valid;
    assign bus1.ld_data    = bus0.ld_data;
    assign bus1.W          = bus0.W;
    assign bus1.J          = bus0.J;
    assign bus1.Valid      = bus0.Valid;
    assign bus1.MinCost    = bus0.MinCost;
    assign bus1.MatchCount = bus0.MatchCount;

    logic [1:0]       jr, dn, ps, fm, fc, tmo, rdy;
    logic [1:0][6:0]  cst;
    logic [1:0][15:0] cy;

    assign rdy[0] = bus0.ld_ready;
    assign rdy[1] = bus1.ld_ready;
    assign cst[0] = bus0.Cost;
    assign cst[1] = bus1.Cost;

    jam_cost_host #(.TIMEOUT(4096), .CYC_W(16)) dut0 (
        .CLK(CLK), .RST(RST), .bus(bus0),
        .exp_valid(exp_valid), .exp_min(exp_min), .exp_count(exp_count), .start(start),
        .jam_rst(jr[0]), .done(dn[0]), .pass(ps[0]), .fail_min(fm[0]),
        .fail_count(fc[0]), .timeout(tmo[0]), .cycles(cy[0])
    );

    jam_cost_host #(.TIMEOUT(64), .CYC_W(16)) dut1 (
        .CLK(CLK), .RST(RST), .bus(bus1),
        .exp_valid(exp_valid), .exp_min(exp_min), .exp_count(exp_count), .start(start),
        .jam_rst(jr[1]), .done(dn[1]), .pass(ps[1]), .fail_min(fm[1]),
        .fail_count(fc[1]), .timeout(tmo[1]), .cycles(cy[1])
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    // ---------------- model ----------------
    int         lim [2] = '{4096, 64};
    int         m_cnt [2];
    int         m_cyc [2];
    logic [1:0] m_expl, m_run, m_fin, m_pass, m_fmin, m_fcnt, m_tmo;
    logic [9:0] m_em [2];
    logic [3:0] m_ec [2];
    logic [6:0] m_mem [2][64];

    initial begin
        m_cnt = '{0, 0}; m_cyc = '{0, 0};
        m_expl = '0; m_run = '0; m_fin = '0; m_pass = '0;
        m_fmin = '0; m_fcnt = '0; m_tmo = '0;
        forever begin
            @(posedge CLK);
            for (int i = 0; i < 2; i++) begin
                if (RST) begin
                    m_cnt[i] = 0; m_cyc[i] = 0; m_expl[i] = 0; m_run[i] = 0; m_fin[i] = 0;
                    m_pass[i] = 0; m_fmin[i] = 0; m_fcnt[i] = 0; m_tmo[i] = 0;
                end else if (m_fin[i]) begin
                    if (start) begin
                        m_cnt[i] = 0; m_cyc[i] = 0; m_expl[i] = 0; m_fin[i] = 0;
                        m_pass[i] = 0; m_fmin[i] = 0; m_fcnt[i] = 0; m_tmo[i] = 0;
                    end
                end else if (m_run[i]) begin
                    if (bus0.Valid) begin
                        m_run[i]  = 0;
                        m_fin[i]  = 1;
                        m_fmin[i] = (bus0.MinCost != m_em[i]);
                        m_fcnt[i] = (bus0.MatchCount != m_ec[i]);
                        m_pass[i] = !m_fmin[i] && !m_fcnt[i];
                    end else if (m_cyc[i] == lim[i] - 1) begin
                        m_run[i] = 0;
                        m_fin[i] = 1;
                        m_tmo[i] = 1;
                    end else if (m_cyc[i] < 65535) begin
                        m_cyc[i]++;
                    end
                end else begin
                    if (m_cnt[i] == 64 && m_expl[i]) begin
                        m_run[i] = 1;
                        m_cyc[i] = 0;
                    end
                    if (bus0.ld_valid && m_cnt[i] < 64) begin
                        m_mem[i][m_cnt[i]] = bus0.ld_data;
                        m_cnt[i]++;
                    end
                    if (exp_valid) begin
                        m_em[i] = exp_min;
                        m_ec[i] = exp_count;
                        m_expl[i] = 1;
                    end
                end
            end
        end
    end

    // Fields: {ld_ready, jam_rst, done, pass, fail_min, fail_count, timeout, Cost[6:0], cycles[15:0]}
    logic [29:0] got_v, exp_v;
    logic [6:0]  m_cost;
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            got_v = {rdy[i], jr[i], dn[i], ps[i], fm[i], fc[i], tmo[i], cst[i], cy[i]};
            m_cost = m_run[i] ? m_mem[i][int'(bus0.W) * 8 + int'(bus0.J)] : 7'd0;
            if (RST)
                exp_v = {1'b1, 1'b1, 5'b0, 7'd0, 16'd0};
            else
                exp_v = {!m_run[i] && !m_fin[i] && (m_cnt[i] < 64), !m_run[i], m_fin[i],
                         m_pass[i], m_fmin[i], m_fcnt[i], m_tmo[i], m_cost, 16'(m_cyc[i])};
            chk($sformatf("d%0d_outputs", i), 32'(got_v), 32'(exp_v));
        end
    end

    // ---------------- stimulus ----------------
    logic [6:0] vec [64];

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic load();
        for (int k = 0; k < 64; k++) begin
            bus0.ld_valid = 1'b1;
            bus0.ld_data  = vec[k];
            cyc(1);
        end
        bus0.ld_valid = 1'b0;
    endtask

    task automatic strobe(input logic [9:0] mn, input logic [3:0] ct);
        exp_valid = 1'b1;
        exp_min   = mn;
        exp_count = ct;
        cyc(1);
        exp_valid = 1'b0;
    endtask

    task automatic wait_run(input string name);
        int n;
        n = 0;
        while (jr[0] && n < 20) begin
            cyc(1);
            n++;
        end
        chk(name, 32'(jr[0]), 0);
    endtask

    task automatic result(input logic [9:0] mn, input logic [3:0] ct);
        bus0.Valid      = 1'b1;
        bus0.MinCost    = mn;
        bus0.MatchCount = ct;
        cyc(1);
        bus0.Valid = 1'b0;
    endtask

    task automatic restart();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic diag_matrix();
        for (int k = 0; k < 64; k++) vec[k] = (k / 8 == k % 8) ? 7'd0 : 7'd10;
    endtask

    initial begin
        bus0.ld_valid = 0; bus0.ld_data = 0; bus0.W = 0; bus0.J = 0;
        bus0.Valid = 0; bus0.MinCost = 0; bus0.MatchCount = 0;

        // T1 reset
        cyc(2);
        chk("t1_jam_rst",  32'(jr[0]), 1);
        chk("t1_ld_ready", 32'(rdy[0]), 1);
        chk("t1_cost",     32'(cst[0]), 0);
        chk("t1_done",     32'(dn[0]), 0);
        chk("t1_cycles",   32'(cy[0]), 0);
        RST = 1'b0;
        cyc(1);

        // T2 load / serve
        for (int k = 0; k < 64; k++) vec[k] = 7'(k % 128);
        load();
        strobe(10'd252, 4'd0);
        wait_run("t2_run_start");
        bus0.W = 3'd3; bus0.J = 3'd5; #1;
        chk("t2_cost_3_5_d0", 32'(cst[0]), 29);
        chk("t2_cost_3_5_d1", 32'(cst[1]), 29);
        bus0.W = 3'd7; bus0.J = 3'd7; #1;
        chk("t2_cost_7_7", 32'(cst[0]), 63);
        cyc(1);
        result(10'd252, 4'd0);
        chk("t2_pass", 32'(ps[0]), 1);
        restart();

        // T3 pass at RUN cycle 200
        diag_matrix();
        load();
        strobe(10'd0, 4'd1);
        wait_run("t3_run_start");
        bus0.W = 3'd2; bus0.J = 3'd2; #1;
        chk("t3_cost_diag", 32'(cst[0]), 0);
        cyc(200);
        result(10'd0, 4'd1);
        chk("t3_done",   32'(dn[0]), 1);
        chk("t3_pass",   32'(ps[0]), 1);
        chk("t3_cycles", 32'(cy[0]), 200);
        restart();

        // T4 count mismatch
        load();
        strobe(10'd0, 4'd1);
        wait_run("t4_run_start");
        cyc(200);
        result(10'd0, 4'd2);
        chk("t4_done",       32'(dn[0]), 1);
        chk("t4_pass",       32'(ps[0]), 0);
        chk("t4_fail_count", 32'(fc[0]), 1);
        chk("t4_fail_min",   32'(fm[0]), 0);
        restart();

        // T5a timeout on d1 (TIMEOUT=64)
        load();
        strobe(10'd0, 4'd1);
        wait_run("t5_run_start");
        cyc(64);
        chk("t5_done",       32'(dn[1]), 1);
        chk("t5_timeout",    32'(tmo[1]), 1);
        chk("t5_pass",       32'(ps[1]), 0);
        chk("t5_cycles",     32'(cy[1]), 63);
        chk("t5_d0_running", 32'(jr[0]), 0);
        result(10'd0, 4'd1);
        restart();

        // T5b Valid on the timeout cycle wins
        load();
        strobe(10'd0, 4'd1);
        wait_run("t5b_run_start");
        cyc(63);
        result(10'd0, 4'd1);
        chk("t5b_done",    32'(dn[1]), 1);
        chk("t5b_timeout", 32'(tmo[1]), 0);
        chk("t5b_pass",    32'(ps[1]), 1);
        chk("t5b_cycles",  32'(cy[1]), 63);
        restart();

        // T6 ordering and mid-RUN reset
        for (int k = 0; k < 64; k++) vec[k] = 7'((k * 3 + 7) % 128);
        load();
        cyc(3);
        chk("t6_ld_ready_full", 32'(rdy[0]), 0);
        chk("t6_jam_rst_held",  32'(jr[0]), 1);
        bus0.ld_valid = 1'b1; bus0.ld_data = 7'd5;
        cyc(1);
        bus0.ld_valid = 1'b0;
        strobe(10'd0, 4'd0);
        wait_run("t6_run_start");
        cyc(5);
        RST = 1'b1; #1;
        chk("t6_rst_jam_rst",  32'(jr[0]), 1);
        chk("t6_rst_ld_ready", 32'(rdy[0]), 1);
        chk("t6_rst_done",     32'(dn[0]), 0);
        cyc(1);
        RST = 1'b0;
        cyc(1);
        for (int k = 0; k < 64; k++) vec[k] = 7'((k * 5 + 1) % 128);
        load();
        strobe(10'd0, 4'd0);
        wait_run("t6_rerun_start");
        bus0.W = 3'd2; bus0.J = 3'd6; #1;
        chk("t6_cost_2_6", 32'(cst[0]), 111);
        bus0.W = 3'd0; bus0.J = 3'd0; #1;
        chk("t6_cost_0_0", 32'(cst[0]), 1);
        bus0.W = 3'd7; bus0.J = 3'd7; #1;
        chk("t6_cost_7_7", 32'(cst[1]), 60);
        cyc(2);
        result(10'd3, 4'd0);
        chk("t6_fail_min", 32'(fm[0]), 1);
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
